// File: rtl/clint_responder.sv
// clint_responder: core-local interruptor (msip, mtime, mtimecmp) on the MMIO bus.
// Optional prescaler for mtime enabled by defining CLINT_PRESCALE_EN.
//
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   req_valid/ready   - request handshake (accepted when both high)
//   req_write         - 1 = store, 0 = load
//   req_addr          - byte address, bits [2:0] ignored
//   req_wdata/wmask   - store data and per-bit write mask
//   resp_valid/ready  - response handshake
//   resp_rdata        - load data (0 for stores)
//   resp_err          - address not mapped to a register
//   timer_irq         - mtime >= mtimecmp (unsigned)
//   soft_irq          - msip bit 0
module clint_responder #(
    parameter logic [63:0] BASE     = 64'h0200_0000,
    parameter int unsigned TICK_DIV = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [63:0] req_wmask,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        timer_irq,
    output logic        soft_irq
);

    localparam logic [15:0] OFF_MSIP = 16'h0000;
    localparam logic [15:0] OFF_CMP  = 16'h4000;
    localparam logic [15:0] OFF_TIME = 16'hBFF8;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        msip_q, msip_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;

    logic [63:0] offset;
    logic        in_win;
    logic        sel_msip, sel_cmp, sel_time;
    logic        accept, wr;
    logic [63:0] rd_data;
    logic        rd_err;
    logic        tick;

    function automatic logic [63:0] merge(
        input logic [63:0] old,
        input logic [63:0] wd,
        input logic [63:0] wm
    );
        return (old & ~wm) | (wd & wm);
    endfunction

    // Window test done on the offset so BASE need not be 64 KiB aligned.
    assign offset   = req_addr - BASE;
    assign in_win   = (offset[63:16] == 48'd0);
    assign sel_msip = in_win && (offset[15:3] == OFF_MSIP[15:3]);
    assign sel_cmp  = in_win && (offset[15:3] == OFF_CMP[15:3]);
    assign sel_time = in_win && (offset[15:3] == OFF_TIME[15:3]);

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign timer_irq  = (mtime_q >= mtimecmp_q);
    assign soft_irq   = msip_q;

    assign accept = req_ready & req_valid;
    assign wr     = accept & req_write;

    always_comb begin
        rd_data = 64'd0;
        rd_err  = 1'b1;
        unique case (1'b1)
            sel_msip: begin
                rd_data = {63'd0, msip_q};
                rd_err  = 1'b0;
            end
            sel_cmp: begin
                rd_data = mtimecmp_q;
                rd_err  = 1'b0;
            end
            sel_time: begin
                rd_data = mtime_q;
                rd_err  = 1'b0;
            end
            default: ;
        endcase
    end

`ifdef CLINT_PRESCALE_EN
    localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);

    logic [15:0] presc_q, presc_d;

    assign tick = (presc_q == DIV_LAST);

    // A write to mtime restarts the tick period.
    always_comb begin
        presc_d = tick ? 16'd0 : presc_q + 16'd1;
        if (wr && sel_time) presc_d = 16'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) presc_q <= 16'd0;
        else     presc_q <= presc_d;
    end
`else
    logic unused_div;

    assign tick       = 1'b1;
    assign unused_div = ^TICK_DIV;
`endif

    logic unused_low;
    assign unused_low = ^offset[2:0];

    // Request/response FSM; read data is captured on the accept edge.
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = RESP;
                    rdata_d = req_write ? 64'd0 : rd_data;
                    err_d   = rd_err;
                end
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
        endcase
    end

    // Register updates; an mtime write overrides the tick increment.
    always_comb begin
        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        if (wr && sel_msip && req_wmask[0]) msip_d = req_wdata[0];
        if (wr && sel_cmp)
            mtimecmp_d = merge(mtimecmp_q, req_wdata, req_wmask);
        if (wr && sel_time)
            mtime_d = merge(mtime_q, req_wdata, req_wmask);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rdata_q    <= 64'd0;
            err_q      <= 1'b0;
            msip_q     <= 1'b0;
            mtime_q    <= 64'd0;
            mtimecmp_q <= '1;
        end else begin
            state_q    <= state_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            msip_q     <= msip_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
        end
    end

endmodule

// File: tb/tb_clint_responder.sv
// tb_clint_responder: randomized scoreboard bench for clint_responder.
// Expected responses are queued by the driver and checked by a monitor.
module tb_clint_responder;

    localparam logic [63:0] BASE = 64'h0200_0000;
`ifdef CLINT_PRESCALE_EN
    localparam int TD = 4;
`else
    localparam int TD = 1;
`endif

    logic        clk, rst;
    logic        req_valid, req_ready, req_write;
    logic [63:0] req_addr, req_wdata, req_wmask;
    logic        resp_valid, resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err, timer_irq, soft_irq;

    clint_responder #(.BASE(BASE), .TICK_DIV(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .timer_irq(timer_irq), .soft_irq(soft_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    int     n_chk = 0;
    int     n_fail = 0;
    longint cyc = 0;
    bit     in_rst = 1'b1;

    // Reference state: mtime is held as a base value plus elapsed time.
    logic [63:0] m_cmp;
    logic        m_msip;
    logic [63:0] mt_base;
    longint      mt_cyc;
    exp_t        q[$];
    exp_t        mon_e;

    function automatic logic [63:0] mtime_now();
        return mt_base + 64'((cyc - mt_cyc) / TD);
    endfunction

    function automatic logic [63:0] merge(
        input logic [63:0] o, input logic [63:0] w, input logic [63:0] m);
        return (o & ~m) | (w & m);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic model_reset();
        m_cmp   = '1;
        m_msip  = 1'b0;
        mt_base = 64'd0;
        mt_cyc  = cyc;
        q.delete();
    endtask

    always @(negedge clk) begin
        if (!in_rst) begin
            chk("timer_irq", timer_irq, mtime_now() >= m_cmp);
            chk("soft_irq", soft_irq, m_msip);
            if (resp_valid && resp_ready) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL resp_unexpected: got response %h with no request outstanding",
                             resp_rdata);
                end else begin
                    mon_e = q.pop_front();
                    chk("resp_rdata", resp_rdata, mon_e.rdata);
                    chk("resp_err", resp_err, mon_e.err);
                end
            end
        end
    end

    task automatic txn(input bit wr, input logic [15:0] off_in,
                       input logic [63:0] wd, input logic [63:0] wm,
                       input int stall);
        exp_t        e;
        logic [15:0] off;
        logic [63:0] oldt;
        int          n;
        off  = off_in & 16'hFFF8;
        oldt = mtime_now();
        chk("req_ready_idle", req_ready, 1);
        e.err   = !(off == 16'h0000 || off == 16'h4000 || off == 16'hBFF8);
        e.rdata = 64'd0;
        if (!wr) begin
            if (off == 16'h0000)      e.rdata = {63'd0, m_msip};
            else if (off == 16'h4000) e.rdata = m_cmp;
            else if (off == 16'hBFF8) e.rdata = oldt;
        end
        q.push_back(e);
        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = BASE + 64'(off) + 64'($urandom_range(0, 7));
        req_wdata  = wd;
        req_wmask  = wm;
        resp_ready = (stall == 0);
        step();
        if (wr) begin
            if (off == 16'h0000 && wm[0]) m_msip = wd[0];
            if (off == 16'h4000) m_cmp = merge(m_cmp, wd, wm);
            if (off == 16'hBFF8) begin
                mt_base = merge(oldt, wd, wm);
                mt_cyc  = cyc;
            end
        end
        req_valid = 1'b0;
        for (int i = 0; i < stall; i++) begin
            // A competing store must not be accepted while stalled.
            req_valid = 1'b1;
            req_write = 1'b1;
            req_addr  = BASE + 64'h4000;
            req_wdata = {$urandom, $urandom};
            req_wmask = '1;
            chk("stall_resp_valid", resp_valid, 1);
            chk("stall_req_ready", req_ready, 0);
            chk("stall_rdata", resp_rdata, e.rdata);
            chk("stall_err", resp_err, e.err);
            step();
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        n = 0;
        while (!resp_valid && n < 8) begin
            step();
            n++;
        end
        chk("resp_valid_wait", resp_valid, 1);
        if (resp_valid) step();
    endtask

    function automatic logic [63:0] rand_mask();
        logic [63:0] m;
        for (int b = 0; b < 8; b++)
            m[b*8 +: 8] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
        return m;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] offs[5];
        logic [15:0] o;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 64'd0;
        req_wdata  = 64'd0;
        req_wmask  = 64'd0;
        resp_ready = 1'b1;
        step();
        step();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_timer_irq", timer_irq, 0);
        chk("rst_soft_irq", soft_irq, 0);
        rst = 1'b0;
        model_reset();
        in_rst = 1'b0;
        step();

        txn(0, 16'hBFF8, 0, 0, 0);
        txn(0, 16'h4000, 0, 0, 0);

        txn(1, 16'h4000, 64'h20, '1, 0);
        txn(1, 16'hBFF8, 64'h0, '1, 0);
        repeat (34 * TD) begin
            chk("timer_rise", timer_irq, mtime_now() >= m_cmp);
            step();
        end
        chk("timer_high", timer_irq, 1);

        txn(1, 16'h0000, 64'h1, 64'hFF, 0);
        chk("soft_irq_set", soft_irq, 1);
        txn(0, 16'h0000, 0, 0, 0);
        txn(1, 16'h0000, 64'h0, 64'h0, 0);
        txn(0, 16'h0000, 0, 0, 0);
        txn(1, 16'h0000, 64'h0, 64'hFF, 0);

        txn(0, 16'h1000, 0, 0, 0);
        txn(1, 16'h1000, '1, '1, 0);
        txn(0, 16'h4000, 0, 0, 0);
        txn(0, 16'h0000, 0, 0, 0);

        txn(0, 16'hBFF8, 0, 0, 5);

        txn(1, 16'hBFF8, '1, '1, 0);
        txn(0, 16'hBFF8, 0, 0, 0);
        txn(1, 16'hBFF8, '1, '1, 0);
        repeat (TD) step();
        txn(0, 16'hBFF8, 0, 0, 0);

        offs[0] = 16'h0000;
        offs[1] = 16'h4000;
        offs[2] = 16'hBFF8;
        offs[3] = 16'h1000;
        for (int k = 0; k < 150; k++) begin
            offs[4] = 16'($urandom_range(0, 16'hFFFF));
            o = offs[$urandom_range(0, 4)];
            txn(1'($urandom_range(0, 1)), o, {$urandom, $urandom},
                rand_mask(), $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) step();
        end

        txn(1, 16'h4000, 64'h5, '1, 0);
        txn(1, 16'h0000, 64'h1, '1, 0);
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_addr   = BASE + 64'hBFF8;
        resp_ready = 1'b0;
        step();
        req_valid = 1'b0;
        chk("pre_rst_resp_valid", resp_valid, 1);
        step();
        rst    = 1'b1;
        in_rst = 1'b1;
        #1;
        chk("mid_rst_resp_valid", resp_valid, 0);
        chk("mid_rst_req_ready", req_ready, 1);
        step();
        step();
        rst = 1'b0;
        model_reset();
        in_rst     = 1'b0;
        resp_ready = 1'b1;
        txn(0, 16'h4000, 0, 0, 0);
        txn(0, 16'h0000, 0, 0, 0);
        txn(0, 16'hBFF8, 0, 0, 0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
